// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared constants and types for the memory responder.
// Holds the loader command codes, the loader FSM state type and the default
// address / instruction / data widths.
// Build option: MEM_READBACK_EN adds the RB state (dmem readback command).
package mem_responder_pkg;

    localparam int unsigned AW_DEFAULT = 8;
    localparam int unsigned IW_DEFAULT = 16;
    localparam int unsigned DW_DEFAULT = 8;

    localparam logic [7:0] CMD_IMEM_WR = 8'h01;
    localparam logic [7:0] CMD_DMEM_WR = 8'h02;
    localparam logic [7:0] CMD_RUN     = 8'h03;
    localparam logic [7:0] CMD_STOP    = 8'h04;
    localparam logic [7:0] CMD_RDBK    = 8'h05;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_LEN   = 3'd2,
        S_HI    = 3'd3,
        S_LO    = 3'd4,
        S_DBYTE = 3'd5
`ifdef MEM_READBACK_EN
        ,
        S_RB    = 3'd6
`endif
    } state_e;

endpackage

// File: rtl/sync_wr_ram.sv
// sync_wr_ram: register-file RAM, one synchronous write port and NRD
// asynchronous read ports. Contents are not reset.
// Ports: clk; we/wr_addr/wr_data write port; rd_addr[i] -> rd_data[i].
module sync_wr_ram #(
    parameter int unsigned AW  = 8,
    parameter int unsigned W   = 8,
    parameter int unsigned NRD = 1
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          wr_addr,
    input  logic [W-1:0]           wr_data,
    input  logic [NRD-1:0][AW-1:0] rd_addr,
    output logic [NRD-1:0][W-1:0]  rd_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read ports
    always_comb begin
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_data[i] = mem[rd_addr[i]];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: instruction/data memory for the single-cycle cpu plus a
// byte-stream loader that fills memories and starts/stops the cpu.
// Ports: CLK/RESET (async, active-low); PC->Iin and DataA->Din are
// combinational reads; DataB/MW is the cpu store port (honoured only while
// running); LD_VALID/LD_DATA/LD_READY is the loader byte stream; CPU_RESET,
// EN_L run control; BUSY frame in progress; ERR rejected-command pulse.
// Build option: MEM_READBACK_EN adds RB_VALID/RB_DATA/RB_READY and cmd 0x05.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned IW = IW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [AW-1:0] PC,
    input  logic [DW-1:0] DataA,
    input  logic [DW-1:0] DataB,
    input  logic          MW,
    output logic [IW-1:0] Iin,
    output logic [DW-1:0] Din,
    output logic          CPU_RESET,
    output logic          EN_L,
    input  logic          LD_VALID,
    input  logic [7:0]    LD_DATA,
    output logic          LD_READY,
    output logic          BUSY,
    output logic          ERR
`ifdef MEM_READBACK_EN
    ,
    output logic          RB_VALID,
    output logic [7:0]    RB_DATA,
    input  logic          RB_READY
`endif
);

`ifdef MEM_READBACK_EN
    localparam int unsigned DMEM_NRD = 2;
`else
    localparam int unsigned DMEM_NRD = 1;
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    hi_q, hi_d;
    logic          running_q, running_d;
    logic          err_q, err_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          ld_ready_q, ld_ready_d;
    logic          busy_q, busy_d;

    logic          accept;
    logic          unit_done;
    logic          imem_we;
    logic          dmem_ld_we;
    logic          dmem_we;
    logic [AW-1:0] dmem_wa;
    logic [DW-1:0] dmem_wd;
    logic [0:0][IW-1:0]          imem_rd;
    logic [DMEM_NRD-1:0][DW-1:0] dmem_rd;
    logic [DMEM_NRD-1:0][AW-1:0] dmem_ra;

    assign accept = LD_VALID & ld_ready_q;

    // Loader FSM and run control
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        hi_d        = hi_q;
        running_d   = running_q;
        err_d       = 1'b0;
        imem_we     = 1'b0;
        dmem_ld_we  = 1'b0;
        unit_done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (LD_DATA)
                        CMD_IMEM_WR, CMD_DMEM_WR: begin
                            // Memory-image writes are refused while the cpu owns dmem
                            if (running_q) begin
                                err_d = 1'b1;
                            end else begin
                                cmd_d   = LD_DATA;
                                state_d = S_ADDR;
                            end
                        end
`ifdef MEM_READBACK_EN
                        CMD_RDBK: begin
                            cmd_d   = LD_DATA;
                            state_d = S_ADDR;
                        end
`endif
                        CMD_RUN:  running_d = 1'b1;
                        CMD_STOP: running_d = 1'b0;
                        default:  err_d = 1'b1;
                    endcase
                end
            end
            S_ADDR: begin
                if (accept) begin
                    addr_d  = AW'(LD_DATA);
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    // LEN of 0 counts down through 255..1, i.e. 256 units
                    cnt_d = LD_DATA;
                    if (cmd_q == CMD_IMEM_WR) begin
                        state_d = S_HI;
                    end else if (cmd_q == CMD_DMEM_WR) begin
                        state_d = S_DBYTE;
                    end else begin
`ifdef MEM_READBACK_EN
                        state_d = S_RB;
`else
                        state_d = S_IDLE;
`endif
                    end
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_d    = LD_DATA;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    imem_we   = 1'b1;
                    unit_done = 1'b1;
                    state_d   = S_HI;
                end
            end
            S_DBYTE: begin
                if (accept) begin
                    dmem_ld_we = 1'b1;
                    unit_done  = 1'b1;
                end
            end
`ifdef MEM_READBACK_EN
            S_RB: begin
                if (RB_READY) begin
                    unit_done = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Per-unit address/count advance; frame ends on the last unit
        if (unit_done) begin
            addr_d = addr_q + AW'(1);
            cnt_d  = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
                state_d = S_IDLE;
            end
        end

        cpu_reset_d = ~running_d;
        busy_d      = (state_d != S_IDLE);
`ifdef MEM_READBACK_EN
        ld_ready_d  = (state_d != S_RB);
`else
        ld_ready_d  = 1'b1;
`endif
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            cmd_q       <= '0;
            hi_q        <= '0;
            running_q   <= 1'b0;
            err_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
            ld_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            hi_q        <= hi_d;
            running_q   <= running_d;
            err_q       <= err_d;
            cpu_reset_q <= cpu_reset_d;
            ld_ready_q  <= ld_ready_d;
            busy_q      <= busy_d;
        end
    end

`ifdef MEM_READBACK_EN
    logic rb_valid_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= (state_d == S_RB);
        end
    end

    assign RB_VALID = rb_valid_q;
    assign RB_DATA  = 8'(dmem_rd[1]);
    assign dmem_ra  = {addr_q, AW'(DataA)};
`else
    assign dmem_ra  = AW'(DataA);
`endif

    // dmem write port belongs to the cpu while running, the loader otherwise
    assign dmem_we = running_q ? MW : dmem_ld_we;
    assign dmem_wa = running_q ? AW'(DataA) : addr_q;
    assign dmem_wd = running_q ? DataB : DW'(LD_DATA);

    sync_wr_ram #(.AW(AW), .W(IW), .NRD(1)) u_imem (
        .clk     (CLK),
        .we      (imem_we),
        .wr_addr (addr_q),
        .wr_data (IW'({hi_q, LD_DATA})),
        .rd_addr (PC),
        .rd_data (imem_rd)
    );

    sync_wr_ram #(.AW(AW), .W(DW), .NRD(DMEM_NRD)) u_dmem (
        .clk     (CLK),
        .we      (dmem_we),
        .wr_addr (dmem_wa),
        .wr_data (dmem_wd),
        .rd_addr (dmem_ra),
        .rd_data (dmem_rd)
    );

    assign Iin       = imem_rd[0];
    assign Din       = dmem_rd[0];
    assign CPU_RESET = cpu_reset_q;
    assign EN_L      = running_q;
    assign LD_READY  = ld_ready_q;
    assign BUSY      = busy_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder.
// Reference model: plain arrays of imem/dmem contents plus a running flag.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pc, data_a, data_b;
    logic        mw;
    logic [15:0] iin;
    logic [7:0]  din;
    logic        cpu_reset, en_l;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready, busy, err;
`ifdef MEM_READBACK_EN
    logic        rb_valid, rb_ready;
    logic [7:0]  rb_data;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] imem_m [256];
    logic [7:0]  dmem_m [256];

    always #5 clk = ~clk;

    mem_responder dut (
        .CLK       (clk),
        .RESET     (rst_n),
        .PC        (pc),
        .DataA     (data_a),
        .DataB     (data_b),
        .MW        (mw),
        .Iin       (iin),
        .Din       (din),
        .CPU_RESET (cpu_reset),
        .EN_L      (en_l),
        .LD_VALID  (ld_valid),
        .LD_DATA   (ld_data),
        .LD_READY  (ld_ready),
        .BUSY      (busy),
        .ERR       (err)
`ifdef MEM_READBACK_EN
        ,
        .RB_VALID  (rb_valid),
        .RB_DATA   (rb_data),
        .RB_READY  (rb_ready)
`endif
    );

    // One loader byte, accepted at the next rising edge; returns 1 time unit after it
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = b;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    // Full write frame with random payload; updates the reference model
    task automatic load_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] len);
        int n;
        logic [7:0]  a;
        logic [15:0] w;
        n = (len == 8'd0) ? 256 : int'(len);
        send_byte(cmd);
        send_byte(addr);
        send_byte(len);
        a = addr;
        for (int u = 0; u < n; u++) begin
            w = 16'($urandom);
            if (cmd == 8'h01) begin
                send_byte(w[15:8]);
                send_byte(w[7:0]);
                imem_m[a] = w;
            end else begin
                send_byte(w[7:0]);
                dmem_m[a] = w[7:0];
            end
            a = a + 8'd1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL reset_cpu_reset got %b want 1", cpu_reset); end
        checks++; if (en_l !== 1'b0)      begin failures++; $display("FAIL reset_en_l got %b want 0", en_l); end
        checks++; if (ld_ready !== 1'b1)  begin failures++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (err !== 1'b0)       begin failures++; $display("FAIL reset_err got %b want 0", err); end
`ifdef MEM_READBACK_EN
        checks++; if (rb_valid !== 1'b0)  begin failures++; $display("FAIL reset_rb_valid got %b want 0", rb_valid); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || cpu_reset !== 1'b1) begin failures++; $display("FAIL post_reset_idle got busy=%b cpu_reset=%b want 0/1", busy, cpu_reset); end
    endtask

    task automatic test_imem_write;
        logic [7:0] bytes [7];
        bytes = '{8'h01, 8'h10, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34};
        for (int i = 0; i < 7; i++) begin
            send_byte(bytes[i]);
            if (i == 4) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL imem_busy_mid got %b want 1", busy); end
            end
        end
        imem_m[8'h10] = 16'hABCD;
        imem_m[8'h11] = 16'h1234;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL imem_busy_end got %b want 0", busy); end
        pc = 8'h10; #1;
        checks++; if (iin !== 16'hABCD) begin failures++; $display("FAIL imem_word0 got %h want abcd", iin); end
        pc = 8'h11; #1;
        checks++; if (iin !== 16'h1234) begin failures++; $display("FAIL imem_word1 got %h want 1234", iin); end
    endtask

    task automatic test_dmem_wrap;
        send_byte(8'h02); send_byte(8'hFF); send_byte(8'h02);
        send_byte(8'h55);
        send_byte(8'h66);
        dmem_m[8'hFF] = 8'h55;
        dmem_m[8'h00] = 8'h66;
        data_a = 8'hFF; #1;
        checks++; if (din !== 8'h55) begin failures++; $display("FAIL dmem_ff got %h want 55", din); end
        data_a = 8'h00; #1;
        checks++; if (din !== 8'h66) begin failures++; $display("FAIL dmem_wrap_00 got %h want 66", din); end
    endtask

    task automatic test_random_frames;
        logic [7:0] cmd, addr, len, a;
        for (int f = 0; f < 16; f++) begin
            cmd  = 8'($urandom_range(1, 2));
            addr = 8'($urandom);
            len  = 8'($urandom_range(1, 6));
            load_frame(cmd, addr, len);
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rand_busy frame %0d got %b want 0", f, busy); end
            a = addr;
            for (int u = 0; u < int'(len); u++) begin
                if (cmd == 8'h01) begin
                    pc = a; #1;
                    checks++; if (iin !== imem_m[a]) begin failures++; $display("FAIL rand_imem addr %h got %h want %h", a, iin, imem_m[a]); end
                end else begin
                    data_a = a; #1;
                    checks++; if (din !== dmem_m[a]) begin failures++; $display("FAIL rand_dmem addr %h got %h want %h", a, din, dmem_m[a]); end
                end
                a = a + 8'd1;
            end
        end
    endtask

    task automatic test_len_zero;
        load_frame(8'h02, 8'h80, 8'h00);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL len0_busy got %b want 0", busy); end
        for (int i = 0; i < 256; i++) begin
            data_a = 8'(i); #1;
            checks++; if (din !== dmem_m[i]) begin failures++; $display("FAIL len0_dmem addr %h got %h want %h", i, din, dmem_m[i]); end
        end
    endtask

    task automatic test_run_and_store;
        send_byte(8'h03);
        checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL run_cpu_reset got %b want 0", cpu_reset); end
        checks++; if (en_l !== 1'b1)      begin failures++; $display("FAIL run_en_l got %b want 1", en_l); end
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL run_idle got err=%b busy=%b want 0/0", err, busy); end
        @(negedge clk);
        mw = 1'b1; data_a = 8'h20; data_b = 8'h7E;
        @(posedge clk); #1;
        mw = 1'b0;
        dmem_m[8'h20] = 8'h7E;
        checks++; if (din !== 8'h7E) begin failures++; $display("FAIL store_20 got %h want 7e", din); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            data_a = 8'($urandom);
            data_b = 8'($urandom);
            mw     = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (mw) dmem_m[data_a] = data_b;
            checks++; if (din !== dmem_m[data_a]) begin failures++; $display("FAIL rand_store addr %h got %h want %h", data_a, din, dmem_m[data_a]); end
        end
        mw = 1'b0;
    endtask

    task automatic test_reject_while_running;
        logic [7:0] bytes [5];
        bytes = '{8'h02, 8'h00, 8'h01, 8'h11, 8'h09};
        for (int i = 0; i < 5; i++) begin
            send_byte(bytes[i]);
            checks++; if (err !== 1'b1) begin failures++; $display("FAIL reject_err byte %h got %b want 1", bytes[i], err); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reject_busy byte %h got %b want 0", bytes[i], busy); end
        end
        @(posedge clk); #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reject_err_pulse got %b want 0", err); end
        checks++; if (en_l !== 1'b1) begin failures++; $display("FAIL reject_still_running got %b want 1", en_l); end
        data_a = 8'h00; #1;
        checks++; if (din !== dmem_m[0]) begin failures++; $display("FAIL reject_dmem_unchanged got %h want %h", din, dmem_m[0]); end
`ifndef MEM_READBACK_EN
        send_byte(8'h05);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL rdbk_unknown_err got %b want 1", err); end
`endif
    endtask

    task automatic test_stop;
        send_byte(8'h04);
        checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL stop_cpu_reset got %b want 1", cpu_reset); end
        checks++; if (en_l !== 1'b0)      begin failures++; $display("FAIL stop_en_l got %b want 0", en_l); end
        @(negedge clk);
        mw = 1'b1; data_a = 8'h20; data_b = ~dmem_m[8'h20];
        @(posedge clk); #1;
        mw = 1'b0;
        checks++; if (din !== dmem_m[8'h20]) begin failures++; $display("FAIL stopped_store_ignored got %h want %h", din, dmem_m[8'h20]); end
    endtask

    task automatic test_reset_midframe;
        logic [15:0] old41;
        load_frame(8'h01, 8'h40, 8'h02);
        old41 = imem_m[8'h41];
        send_byte(8'h01); send_byte(8'h40); send_byte(8'h02);
        send_byte(8'hA1); send_byte(8'hB2);
        send_byte(8'hC3);
        imem_m[8'h40] = 16'hA1B2;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        pc = 8'h40; #1;
        checks++; if (iin !== 16'hA1B2) begin failures++; $display("FAIL midreset_unit0 got %h want a1b2", iin); end
        pc = 8'h41; #1;
        checks++; if (iin !== old41) begin failures++; $display("FAIL midreset_unit1 got %h want %h", iin, old41); end
        // The would-be lo byte now lands in IDLE as an unknown command
        send_byte(8'hD4);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL midreset_idle_err got %b want 1", err); end
        load_frame(8'h01, 8'h41, 8'h01);
        pc = 8'h41; #1;
        checks++; if (iin !== imem_m[8'h41]) begin failures++; $display("FAIL midreset_recover got %h want %h", iin, imem_m[8'h41]); end
    endtask

`ifdef MEM_READBACK_EN
    task automatic test_readback;
        logic [7:0] exp_q [2];
        int idx;
        int cyc;
        exp_q[0] = dmem_m[8'hFF];
        exp_q[1] = dmem_m[8'h00];
        send_byte(8'h05); send_byte(8'hFF); send_byte(8'h02);
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL rb_ld_ready got %b want 0", ld_ready); end
        idx = 0;
        cyc = 0;
        while (idx < 2 && cyc < 50) begin
            @(negedge clk);
            rb_ready = 1'($urandom_range(0, 1));
            #1;
            if (rb_valid && rb_ready) begin
                checks++; if (rb_data !== exp_q[idx]) begin failures++; $display("FAIL rb_data unit %0d got %h want %h", idx, rb_data, exp_q[idx]); end
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        rb_ready = 1'b0;
        checks++; if (idx != 2) begin failures++; $display("FAIL rb_timeout got %0d units want 2", idx); end
        checks++; if (busy !== 1'b0 || ld_ready !== 1'b1) begin failures++; $display("FAIL rb_end got busy=%b ld_ready=%b want 0/1", busy, ld_ready); end
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        pc       = '0;
        data_a   = '0;
        data_b   = '0;
        mw       = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
`ifdef MEM_READBACK_EN
        rb_ready = 1'b0;
`endif
        test_reset();
        test_imem_write();
        test_dmem_wrap();
        test_random_frames();
        test_len_zero();
        test_run_and_store();
        test_reject_while_running();
        test_stop();
        test_reset_midframe();
`ifdef MEM_READBACK_EN
        test_readback();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
